wb_merge: RTL and testbench

Writeback merge stage sitting directly downstream of the memory execute pipe and the integer execute pipe. It collects each pipe's registered writeback triple, orders simultaneous arrivals by program age, and drives the single register-file write port one write per cycle. Excess writes are absorbed in a small FIFO, and the block back-pressures issue before that FIFO can overflow. It also answers a pending-write query from issue.

---
 rtl/wb_merge_pkg.sv | 15 +
 rtl/wb_merge_if.sv | 34 +++
 rtl/wb_merge_fifo.sv | 78 +++++++
 rtl/wb_merge.sv | 138 +++++++++++++
 tb/tb_wb_merge.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_merge_pkg.sv
// Shared types and constants for the writeback merge stage.
package wb_merge_pkg;

  localparam int unsigned REGW  = 5;
  localparam int unsigned DATAW = 32;

  localparam logic [REGW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REGW-1:0]  regdest;
    logic [DATAW-1:0] wbvalue;
    logic             valid;
  } wb_entry_t;

endpackage

// File: rtl/wb_merge_if.sv
// Execute-pipe writeback inputs, issue query/stall and register-file write port.
interface wb_merge_if #(
  parameter int unsigned REGW = wb_merge_pkg::REGW
);
  logic [REGW-1:0] m_wb_regdest;
  logic            m_wb_writereg;
  logic [31:0]     m_wb_wbvalue;
  logic [REGW-1:0] x_wb_regdest;
  logic            x_wb_writereg;
  logic [31:0]     x_wb_wbvalue;
  logic [REGW-1:0] is_wb_rs;
  logic            wb_is_pending;
  logic            wb_is_stall;
  logic            wb_rf_writereg;
  logic [REGW-1:0] wb_rf_regdest;
  logic [31:0]     wb_rf_wbvalue;
  logic            wb_overflow;

  modport master (
    output m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    output x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    output is_wb_rs,
    input  wb_is_pending, wb_is_stall,
    input  wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_overflow
  );

  modport slave (
    input  m_wb_regdest, m_wb_writereg, m_wb_wbvalue,
    input  x_wb_regdest, x_wb_writereg, x_wb_wbvalue,
    input  is_wb_rs,
    output wb_is_pending, wb_is_stall,
    output wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue, wb_overflow
  );
endinterface

// File: rtl/wb_merge_fifo.sv
// Pending-write FIFO: up to two pushes and one pop per cycle, with per-entry
// register match for the issue query and arrival-driven entry invalidation.
module wb_merge_fifo
  import wb_merge_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push0_i,
  input  wb_entry_t       push0_data_i,
  input  logic            push1_i,
  input  wb_entry_t       push1_data_i,
  input  logic            pop_i,
  input  logic            inv0_i,
  input  logic [REGW-1:0] inv0_rd_i,
  input  logic            inv1_i,
  input  logic [REGW-1:0] inv1_rd_i,
  input  logic [REGW-1:0] query_rd_i,
  output wb_entry_t       head_o,
  output logic [CW-1:0]   count_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            query_hit_o
);

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [AW-1:0]    wr0_idx, wr1_idx;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr0_idx = wr_ptr_q[AW-1:0];
  assign wr1_idx = AW'(wr_ptr_q[AW-1:0] + AW'(1));

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    occ         = '0;
    query_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = CW'(AW'(AW'(i) - rd_ptr_q[AW-1:0])) < count_o;
      if (occ[i] && mem_q[i].valid && (mem_q[i].regdest == query_rd_i))
        query_hit_o = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (occ[i] && ((inv0_i && (mem_q[i].regdest == inv0_rd_i)) ||
                     (inv1_i && (mem_q[i].regdest == inv1_rd_i))))
        mem_d[i].valid = 1'b0;
    end
    if (push0_i) mem_d[wr0_idx] = push0_data_i;
    if (push1_i) mem_d[wr1_idx] = push1_data_i;
    wr_ptr_d = wr_ptr_q + CW'(push0_i) + CW'(push1_i);
    rd_ptr_d = rd_ptr_q + CW'(pop_i);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/wb_merge.sv
// Writeback merge: age-orders memory/integer pipe writebacks onto one RF write port.
// Optional build macro WB_MERGE_COALESCE_EN enables superseded-write coalescing.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned REGW  = wb_merge_pkg::REGW,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input logic       clock,
  input logic       reset,
  wb_merge_if.slave bus
);

  logic            m_v_raw, m_v, x_v;
  wb_entry_t       m_ent, x_ent, head, out_e, push0_d, push1_d;
  logic            out_v, pop, push0_en, push1_en, drop;
  logic            inv0, inv1;
  logic [CW-1:0]   fifo_cnt, next_cnt;
  logic            fifo_empty, fifo_full, fifo_hit;

  logic            rf_we_q, rf_we_d;
  logic [REGW-1:0] rf_rd_q, rf_rd_d;
  logic [31:0]     rf_val_q, rf_val_d;
  logic            stall_q, stall_d;
  logic            ovf_q, ovf_d;

  wb_merge_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push0_i      (push0_en),
    .push0_data_i (push0_d),
    .push1_i      (push1_en),
    .push1_data_i (push1_d),
    .pop_i        (pop),
    .inv0_i       (inv0),
    .inv0_rd_i    (bus.m_wb_regdest),
    .inv1_i       (inv1),
    .inv1_rd_i    (bus.x_wb_regdest),
    .query_rd_i   (bus.is_wb_rs),
    .head_o       (head),
    .count_o      (fifo_cnt),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .query_hit_o  (fifo_hit)
  );

  // Qualify arrivals; r0 writes never enter the candidate list.
  always_comb begin
    m_v_raw = bus.m_wb_writereg && (bus.m_wb_regdest != REG_ZERO);
    x_v     = bus.x_wb_writereg && (bus.x_wb_regdest != REG_ZERO);
    m_v     = m_v_raw;
`ifdef WB_MERGE_COALESCE_EN
    if (m_v_raw && x_v && (bus.m_wb_regdest == bus.x_wb_regdest)) m_v = 1'b0;
    inv0 = m_v_raw;
    inv1 = x_v;
`else
    inv0 = 1'b0;
    inv1 = 1'b0;
`endif
    m_ent = '{regdest: bus.m_wb_regdest, wbvalue: bus.m_wb_wbvalue, valid: 1'b1};
    x_ent = '{regdest: bus.x_wb_regdest, wbvalue: bus.x_wb_wbvalue, valid: 1'b1};
  end

  // Candidate order: FIFO head, then M, then X. When the FIFO is full the pop
  // frees exactly one slot, so a dual arrival loses its younger X write.
  always_comb begin
    out_v    = 1'b0;
    out_e    = head;
    pop      = 1'b0;
    push0_en = 1'b0;
    push0_d  = m_ent;
    push1_en = 1'b0;
    push1_d  = x_ent;
    drop     = 1'b0;
    if (!fifo_empty) begin
      pop   = 1'b1;
      out_v = 1'b1;
      if (m_v && x_v) begin
        push0_en = 1'b1;
        push1_en = !fifo_full;
        drop     = fifo_full;
      end else if (m_v) begin
        push0_en = 1'b1;
      end else if (x_v) begin
        push0_en = 1'b1;
        push0_d  = x_ent;
      end
    end else if (m_v) begin
      out_v    = 1'b1;
      out_e    = m_ent;
      push0_en = x_v;
      push0_d  = x_ent;
    end else if (x_v) begin
      out_v = 1'b1;
      out_e = x_ent;
    end
  end

  always_comb begin
    rf_we_d  = out_v && out_e.valid;
    rf_rd_d  = rf_rd_q;
    rf_val_d = rf_val_q;
    if (rf_we_d) begin
      rf_rd_d  = out_e.regdest;
      rf_val_d = out_e.wbvalue;
    end
    next_cnt = fifo_cnt - CW'(pop) + CW'(push0_en) + CW'(push1_en);
    stall_d  = next_cnt >= CW'(DEPTH - 1);
    ovf_d    = ovf_q || drop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_val_q <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_val_q <= rf_val_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.wb_rf_writereg = rf_we_q;
  assign bus.wb_rf_regdest  = rf_rd_q;
  assign bus.wb_rf_wbvalue  = rf_val_q;
  assign bus.wb_is_stall    = stall_q;
  assign bus.wb_overflow    = ovf_q;
  assign bus.wb_is_pending  = (bus.is_wb_rs != REG_ZERO) &&
                              (fifo_hit || (rf_we_q && (rf_rd_q == bus.is_wb_rs)));

endmodule

// File: tb/tb_wb_merge.sv
// Directed self-checking bench for wb_merge (DEPTH=4, REGW=5).
module tb_wb_merge;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  wb_merge_if #(.REGW(5)) bus ();

  wb_merge #(.DEPTH(4), .REGW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic        x_we;
    logic [4:0]  x_rd;
    logic [31:0] x_val;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic        e_stall;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic mwe, input logic [4:0] mrd, input logic [31:0] mval,
                              input logic xwe, input logic [4:0] xrd, input logic [31:0] xval,
                              input logic ewe, input logic [4:0] erd, input logic [31:0] eval_,
                              input logic estall);
    vec_t v;
    v.m_we = mwe; v.m_rd = mrd; v.m_val = mval;
    v.x_we = xwe; v.x_rd = xrd; v.x_val = xval;
    v.e_we = ewe; v.e_rd = erd; v.e_val = eval_; v.e_stall = estall;
    return v;
  endfunction

  task automatic drive(input logic mwe, input logic [4:0] mrd, input logic [31:0] mval,
                       input logic xwe, input logic [4:0] xrd, input logic [31:0] xval);
    bus.m_wb_writereg = mwe; bus.m_wb_regdest = mrd; bus.m_wb_wbvalue = mval;
    bus.x_wb_writereg = xwe; bus.x_wb_regdest = xrd; bus.x_wb_wbvalue = xval;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  int          cap_n;
  logic [4:0]  cap_rd  [16];
  logic [31:0] cap_val [16];
  logic [4:0]  ovf_rd  [10];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.is_wb_rs = 5'd0;
    idle();

    vecs[0]  = mk(1, 5'd3, 32'h11,  0, 5'd0, 32'h0,   1, 5'd3, 32'h11,  0);
    vecs[1]  = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 5'd3, 32'h11,  0);
    vecs[2]  = mk(1, 5'd4, 32'hA,   1, 5'd5, 32'hB,   1, 5'd4, 32'hA,   0);
    vecs[3]  = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 5'd5, 32'hB,   0);
    vecs[4]  = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 5'd5, 32'hB,   0);
    vecs[5]  = mk(0, 5'd0, 32'h0,   1, 5'd0, 32'hFF,  0, 5'd5, 32'hB,   0);
    vecs[6]  = mk(1, 5'd0, 32'h77,  0, 5'd6, 32'h66,  0, 5'd5, 32'hB,   0);
    vecs[7]  = mk(1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 1, 5'd1, 32'h101, 0);
    vecs[8]  = mk(1, 5'd3, 32'h103, 1, 5'd4, 32'h104, 1, 5'd2, 32'h102, 0);
    vecs[9]  = mk(1, 5'd5, 32'h105, 1, 5'd6, 32'h106, 1, 5'd3, 32'h103, 1);
    vecs[10] = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 5'd4, 32'h104, 0);
    vecs[11] = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 5'd5, 32'h105, 0);
    vecs[12] = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 5'd6, 32'h106, 0);
    vecs[13] = mk(0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 5'd6, 32'h106, 0);

    // Reset values
    tick();
    tick();
    chk("rst_we",    32'(bus.wb_rf_writereg), 32'd0);
    chk("rst_rd",    32'(bus.wb_rf_regdest),  32'd0);
    chk("rst_val",   bus.wb_rf_wbvalue,       32'd0);
    chk("rst_stall", 32'(bus.wb_is_stall),    32'd0);
    chk("rst_ovf",   32'(bus.wb_overflow),    32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].m_we, vecs[i].m_rd, vecs[i].m_val, vecs[i].x_we, vecs[i].x_rd, vecs[i].x_val);
      tick();
      chk($sformatf("v%0d_we", i),    32'(bus.wb_rf_writereg), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_rd", i),    32'(bus.wb_rf_regdest),  32'(vecs[i].e_rd));
      chk($sformatf("v%0d_val", i),   bus.wb_rf_wbvalue,       vecs[i].e_val);
      chk($sformatf("v%0d_stall", i), 32'(bus.wb_is_stall),    32'(vecs[i].e_stall));
    end
    chk("tbl_ovf", 32'(bus.wb_overflow), 32'd0);

    // Pending query: r8 in the output register, r5 queued
    drive(1'b1, 5'd8, 32'h81, 1'b1, 5'd5, 32'h52);
    tick();
    idle();
    chk("pq_rd8", 32'(bus.wb_rf_regdest), 32'd8);
    bus.is_wb_rs = 5'd5; #1;
    chk("pend_fifo", 32'(bus.wb_is_pending), 32'd1);
    bus.is_wb_rs = 5'd0; #1;
    chk("pend_r0", 32'(bus.wb_is_pending), 32'd0);
    bus.is_wb_rs = 5'd8; #1;
    chk("pend_outreg", 32'(bus.wb_is_pending), 32'd1);
    bus.is_wb_rs = 5'd9; #1;
    chk("pend_miss", 32'(bus.wb_is_pending), 32'd0);
    bus.is_wb_rs = 5'd5;
    tick();
    chk("pq_val5", bus.wb_rf_wbvalue, 32'h52);
    chk("pend_out5", 32'(bus.wb_is_pending), 32'd1);
    tick();
    chk("pq_we0", 32'(bus.wb_rf_writereg), 32'd0);
    chk("pend_idle", 32'(bus.wb_is_pending), 32'd0);
    bus.is_wb_rs = 5'd0;

    // Same-register dual arrival
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    tick();
    idle();
    chk("co_rd", 32'(bus.wb_rf_regdest), 32'd7);
`ifdef WB_MERGE_COALESCE_EN
    chk("co_val0", bus.wb_rf_wbvalue, 32'h2);
    tick();
    chk("co_we1", 32'(bus.wb_rf_writereg), 32'd0);
`else
    chk("co_val0", bus.wb_rf_wbvalue, 32'h1);
    tick();
    chk("co_we1",  32'(bus.wb_rf_writereg), 32'd1);
    chk("co_val1", bus.wb_rf_wbvalue, 32'h2);
`endif
    tick();
    chk("co_drain", 32'(bus.wb_rf_writereg), 32'd0);

    // Six dual-arrival cycles: X4 and X5 are dropped
    ovf_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11};
    cap_n = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 5'(2*k+1), 32'h200 + 32'(2*k), 1'b1, 5'(2*k+2), 32'h201 + 32'(2*k));
      tick();
      if (bus.wb_rf_writereg && cap_n < 16) begin
        cap_rd[cap_n] = bus.wb_rf_regdest; cap_val[cap_n] = bus.wb_rf_wbvalue; cap_n++;
      end
    end
    idle();
    chk("ov_flag", 32'(bus.wb_overflow), 32'd1);
    chk("ov_stall", 32'(bus.wb_is_stall), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.wb_rf_writereg && cap_n < 16) begin
        cap_rd[cap_n] = bus.wb_rf_regdest; cap_val[cap_n] = bus.wb_rf_wbvalue; cap_n++;
      end
    end
    chk("ov_count", 32'(cap_n), 32'd10);
    for (int j = 0; j < 10 && j < cap_n; j++) begin
      chk($sformatf("ov%0d_rd", j),  32'(cap_rd[j]), 32'(ovf_rd[j]));
      chk($sformatf("ov%0d_val", j), cap_val[j], 32'h1FF + 32'(ovf_rd[j]));
    end
    chk("ov_sticky", 32'(bus.wb_overflow), 32'd1);
    chk("ov_unstall", 32'(bus.wb_is_stall), 32'd0);

    // Reset mid-operation discards queued writes
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(20+2*k), 32'h300 + 32'(k), 1'b1, 5'(21+2*k), 32'h400 + 32'(k));
      tick();
    end
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("mr_we",    32'(bus.wb_rf_writereg), 32'd0);
    chk("mr_rd",    32'(bus.wb_rf_regdest),  32'd0);
    chk("mr_stall", 32'(bus.wb_is_stall),    32'd0);
    chk("mr_ovf",   32'(bus.wb_overflow),    32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("mr_post0", 32'(bus.wb_rf_writereg), 32'd0);
    tick();
    chk("mr_post1", 32'(bus.wb_rf_writereg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
